// File: rtl/wide_axi_stream_zigzag_row_packer.sv
`default_nettype none

`ifndef WIN
`define WIN 16
`endif

// ============================================================================
// Module      : wide_axi_stream_zigzag_row_packer
// Description : Collects one quantised coefficient per beat (zigzag or
//               raster order, optional early end-of-block) into a ping-pong
//               pair of 8x8 banks. Each completed block is then sent as eight
//               raster rows of 8 coefficients, column 0 in the top lane.
//               Coefficients that were never written read back as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_axi_stream_zigzag_row_packer #(
  parameter int ZIGZAG = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [`WIN-1:0]     slave_tdata,
  input  logic                slave_tvalid,
  input  logic                slave_tlast,
  output logic                slave_tready,
  output logic [8*`WIN-1:0]   master_tdata,
  output logic                master_tvalid,
  output logic                master_tlast,
  input  logic                master_tready
);

  localparam int c_win = `WIN;

  // Zigzag index -> raster position (row*8 + col)
  localparam logic [5:0] c_zz [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  // Reader states
  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_send = 1'b1;

  // --------------------------------------------------------------------------
  // Storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [c_win-1:0]   r_mem [0:1][0:63];
  logic [1:0][63:0]   r_mask;
  logic [1:0]         r_full;

  // Writer side
  logic               r_wb;
  logic [5:0]         r_k;
  logic               r_slave_tready;
  logic               w_accept;
  logic               w_close;
  logic [5:0]         w_pos;
  logic [1:0]         w_full_next;
  logic               w_wb_next;

  // Reader side
  logic [0:0]         r_state;
  logic               r_rb;
  logic [2:0]         r_row;
  logic               r_tvalid;
  logic               r_tlast;
  logic [8*c_win-1:0] r_tdata;

  logic [0:0]         w_state_next;
  logic               w_rb_next;
  logic [2:0]         w_row_next;
  logic               w_tvalid_next;
  logic               w_tlast_next;
  logic [8*c_win-1:0] w_tdata_next;
  logic               w_free;
  logic               w_load;
  logic               w_clear;
  logic               w_ld_bank;
  logic [2:0]         w_ld_row;
  logic [8*c_win-1:0] w_ld_data;

  assign slave_tready  = r_slave_tready;
  assign master_tvalid = r_tvalid;
  assign master_tlast  = r_tlast;
  assign master_tdata  = r_tdata;

  // --------------------------------------------------------------------------
  // Writer
  // --------------------------------------------------------------------------
  assign w_accept  = slave_tvalid & r_slave_tready;
  // A block closes on tlast, or on the 64th coefficient even without tlast,
  // so k can never wrap past 63.
  assign w_close   = w_accept & (slave_tlast | (r_k == 6'd63));
  assign w_wb_next = r_wb ^ w_close;

  // Coefficient index to raster position, fixed at elaboration
  generate
    if (ZIGZAG != 0) begin : g_zigzag
      assign w_pos = c_zz[r_k];
    end else begin : g_raster
      assign w_pos = r_k;
    end
  endgenerate

  // Next full flags: the reader frees its bank, the writer fills its own.
  // Both never target the same bank: the writer only writes a bank that is
  // not full and the reader only frees one that is.
  always_comb begin
    w_full_next = r_full;
    if (w_free) begin
      w_full_next[r_rb] = 1'b0;
    end
    if (w_close) begin
      w_full_next[r_wb] = 1'b1;
    end
  end

  // Writer control, bank flags and written masks.
  // A bank's mask is cleared when the reader releases it rather than when the
  // writer switches onto it, so a bank that is still being read is never
  // blanked; an empty bank is therefore always clean when writing starts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wb           <= 1'b0;
      r_k            <= 6'd0;
      r_full         <= 2'b00;
      r_mask         <= '0;
      r_slave_tready <= 1'b1;
    end else begin
      r_full         <= w_full_next;
      r_wb           <= w_wb_next;
      r_slave_tready <= ~w_full_next[w_wb_next];
      if (w_accept) begin
        r_k <= w_close ? 6'd0 : (r_k + 6'd1);
      end
      if (w_free) begin
        r_mask[r_rb] <= '0;
      end
      if (w_accept) begin
        r_mask[r_wb][w_pos] <= 1'b1;
      end
    end
  end

  // Coefficient storage; unwritten entries are hidden by the mask on read
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem[r_wb][w_pos] <= slave_tdata;
    end
  end

  // --------------------------------------------------------------------------
  // Row read-out of the bank/row selected by the reader's next state
  // --------------------------------------------------------------------------
  generate
    for (genvar c = 0; c < 8; c++) begin : g_col
      logic [5:0] w_addr;
      assign w_addr = {w_ld_row, 3'(c)};
      assign w_ld_data[(8-c)*c_win-1 -: c_win] =
        r_mask[w_ld_bank][w_addr] ? r_mem[w_ld_bank][w_addr] : '0;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Reader
  // --------------------------------------------------------------------------
  // Next-state logic: start a block, advance rows, chain into the other bank
  always_comb begin
    w_state_next  = r_state;
    w_rb_next     = r_rb;
    w_row_next    = r_row;
    w_tvalid_next = r_tvalid;
    w_tlast_next  = r_tlast;
    w_free        = 1'b0;
    w_load        = 1'b0;
    w_clear       = 1'b0;
    w_ld_bank     = r_rb;
    w_ld_row      = r_row;
    case (r_state)
      c_st_idle: begin
        if (r_full[r_rb]) begin
          w_state_next  = c_st_send;
          w_row_next    = 3'd0;
          w_load        = 1'b1;
          w_ld_row      = 3'd0;
          w_tvalid_next = 1'b1;
          w_tlast_next  = 1'b0;
        end
      end
      c_st_send: begin
        if (r_tvalid && master_tready) begin
          if (r_row == 3'd7) begin
            w_free    = 1'b1;
            w_rb_next = ~r_rb;
            if (r_full[~r_rb]) begin
              // Next block already waiting: row 0 follows without a bubble
              w_load       = 1'b1;
              w_ld_bank    = ~r_rb;
              w_ld_row     = 3'd0;
              w_row_next   = 3'd0;
              w_tlast_next = 1'b0;
            end else begin
              w_state_next  = c_st_idle;
              w_row_next    = 3'd0;
              w_tvalid_next = 1'b0;
              w_tlast_next  = 1'b0;
              w_clear       = 1'b1;
            end
          end else begin
            w_row_next   = r_row + 3'd1;
            w_load       = 1'b1;
            w_ld_row     = r_row + 3'd1;
            w_tlast_next = (r_row == 3'd6);
          end
        end
      end
      default: begin
        w_state_next  = c_st_idle;
        w_row_next    = 3'd0;
        w_tvalid_next = 1'b0;
        w_tlast_next  = 1'b0;
        w_clear       = 1'b1;
      end
    endcase
  end

  // Output data: a new row on load, zero when leaving SEND, else held
  assign w_tdata_next = w_load ? w_ld_data : (w_clear ? '0 : r_tdata);

  // Reader registers; outputs only move on a load or a handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= c_st_idle;
      r_rb     <= 1'b0;
      r_row    <= 3'd0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rb     <= w_rb_next;
      r_row    <= w_row_next;
      r_tvalid <= w_tvalid_next;
      r_tlast  <= w_tlast_next;
      r_tdata  <= w_tdata_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wide_axi_stream_zigzag_row_packer.sv
`default_nettype none
`timescale 1ns/1ps

`ifndef WIN
`define WIN 16
`endif

// ============================================================================
// Module      : tb_wide_axi_stream_zigzag_row_packer
// Description : Directed bench for the zigzag row packer. One instance runs
//               in zigzag mode, one in raster mode; both see the same input
//               stream and master ready, and each output row is collected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_axi_stream_zigzag_row_packer;

  localparam int c_w = `WIN;

  int tb_zz [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  logic               clock;
  logic               reset_n;
  logic [c_w-1:0]     slave_tdata;
  logic               slave_tvalid;
  logic               slave_tlast;
  logic               master_tready;
  logic               zz_tready, rs_tready;
  logic [8*c_w-1:0]   zz_tdata, rs_tdata;
  logic               zz_tvalid, rs_tvalid;
  logic               zz_tlast, rs_tlast;

  int errors = 0;
  int checks = 0;
  int stall_cycles;
  bit send_timeout;

  logic [c_w-1:0]   tx_data [$];
  bit               tx_last [$];
  logic [8*c_w-1:0] exp_zz  [$];
  logic [8*c_w-1:0] exp_rs  [$];
  logic [8*c_w-1:0] q_zz    [$];
  logic [8*c_w-1:0] q_rs    [$];
  bit               q_zz_last [$];
  bit               q_rs_last [$];

  wide_axi_stream_zigzag_row_packer #(.ZIGZAG(1)) dut_zz (
    .clock(clock), .reset_n(reset_n),
    .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid),
    .slave_tlast(slave_tlast), .slave_tready(zz_tready),
    .master_tdata(zz_tdata), .master_tvalid(zz_tvalid),
    .master_tlast(zz_tlast), .master_tready(master_tready)
  );

  wide_axi_stream_zigzag_row_packer #(.ZIGZAG(0)) dut_rs (
    .clock(clock), .reset_n(reset_n),
    .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid),
    .slave_tlast(slave_tlast), .slave_tready(rs_tready),
    .master_tdata(rs_tdata), .master_tvalid(rs_tvalid),
    .master_tlast(rs_tlast), .master_tready(master_tready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rows that will be taken at the next rising edge (inputs settle at +1ns)
  always @(negedge clock) begin
    if (reset_n) begin
      if (zz_tvalid && master_tready) begin
        q_zz.push_back(zz_tdata);
        q_zz_last.push_back(zz_tlast);
      end
      if (rs_tvalid && master_tready) begin
        q_rs.push_back(rs_tdata);
        q_rs_last.push_back(rs_tlast);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic logic [8*c_w-1:0] mk_row(input int v0, input int v1, input int v2,
                                              input int v3, input int v4, input int v5,
                                              input int v6, input int v7);
    return {v0[c_w-1:0], v1[c_w-1:0], v2[c_w-1:0], v3[c_w-1:0],
            v4[c_w-1:0], v5[c_w-1:0], v6[c_w-1:0], v7[c_w-1:0]};
  endfunction

  function automatic logic [8*c_w-1:0] pack_row(input int img[64], input int r);
    logic [8*c_w-1:0] row;
    int v;
    row = '0;
    for (int c = 0; c < 8; c++) begin
      v = img[r*8+c];
      row[(8-c)*c_w-1 -: c_w] = v[c_w-1:0];
    end
    return row;
  endfunction

  // Queue a block of n beats, value base+k*step; model both output orders
  task automatic queue_block(input int n, input int base, input int step, input bit with_last);
    int img_z[64];
    int img_r[64];
    int v;
    for (int i = 0; i < 64; i++) begin
      img_z[i] = 0;
      img_r[i] = 0;
    end
    for (int k = 0; k < n; k++) begin
      v = (base + k*step) & ((1 << c_w) - 1);
      tx_data.push_back(v[c_w-1:0]);
      tx_last.push_back(with_last && (k == n-1));
      img_z[tb_zz[k]] = v;
      img_r[k] = v;
    end
    if (with_last || n == 64) begin
      for (int r = 0; r < 8; r++) begin
        exp_zz.push_back(pack_row(img_z, r));
        exp_rs.push_back(pack_row(img_r, r));
      end
    end
  endtask

  // Drive every queued beat back to back; count cycles spent waiting
  task automatic send_all();
    int budget;
    stall_cycles = 0;
    send_timeout = 1'b0;
    for (int i = 0; i < tx_data.size(); i++) begin
      slave_tdata  = tx_data[i];
      slave_tlast  = tx_last[i];
      slave_tvalid = 1'b1;
      budget = 0;
      while (!zz_tready && budget < 2000) begin
        @(posedge clock); #1;
        stall_cycles++;
        budget++;
      end
      if (budget >= 2000) begin
        send_timeout = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    slave_tvalid = 1'b0;
    slave_tlast  = 1'b0;
    slave_tdata  = '0;
    tx_data.delete();
    tx_last.delete();
  endtask

  task automatic wait_rows(input int n, output bit ok);
    int budget;
    budget = 0;
    while ((q_zz.size() < n || q_rs.size() < n) && budget < 1000) begin
      @(posedge clock); #1;
      budget++;
    end
    ok = (q_zz.size() >= n) && (q_rs.size() >= n);
  endtask

  task automatic clear_all();
    q_zz.delete(); q_rs.delete(); q_zz_last.delete(); q_rs_last.delete();
    exp_zz.delete(); exp_rs.delete(); tx_data.delete(); tx_last.delete();
  endtask

  task automatic apply_reset();
    @(posedge clock); #4;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    clear_all();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_reset();
    clear_all();
    master_tready = 1'b0;
    queue_block(1, 7, 0, 1'b1);
    queue_block(1, 8, 0, 1'b1);
    send_all();
    checks++;
    if (send_timeout || zz_tready !== 1'b0 || zz_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_precondition: tready=%b tvalid=%b timeout=%b, required tready=0 tvalid=1",
               zz_tready, zz_tvalid, send_timeout);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (zz_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid: got %b, required 0", zz_tvalid);
    end
    checks++;
    if (zz_tdata !== '0) begin
      errors++; $display("FAIL reset_tdata: got %h, required 0", zz_tdata);
    end
    checks++;
    if (zz_tready !== 1'b1 || rs_tready !== 1'b1) begin
      errors++; $display("FAIL reset_tready: got %b/%b, required 1", zz_tready, rs_tready);
    end
    checks++;
    if (zz_tlast !== 1'b0) begin
      errors++; $display("FAIL reset_tlast: got %b, required 0", zz_tlast);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    clear_all();
  endtask

  // ---------------------------------------------------------------------
  task automatic test_full_zigzag();
    bit ok;
    clear_all();
    master_tready = 1'b1;
    queue_block(64, 1, 1, 1'b1);
    send_all();
    checks++;
    if (send_timeout || zz_tvalid !== 1'b0) begin
      errors++; $display("FAIL zz_latency_early: tvalid=%b timeout=%b, required 0", zz_tvalid, send_timeout);
    end
    @(posedge clock); #1;
    checks++;
    if (zz_tvalid !== 1'b1 || zz_tdata !== mk_row(1, 2, 6, 7, 15, 16, 28, 29)) begin
      errors++; $display("FAIL zz_latency_row0: tvalid=%b data=%h, required 1 / row 0", zz_tvalid, zz_tdata);
    end
    wait_rows(8, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL zz_rows_timeout: got %0d rows, required 8", q_zz.size());
    end else begin
      checks++;
      if (q_zz[0] !== mk_row(1, 2, 6, 7, 15, 16, 28, 29)) begin
        errors++; $display("FAIL zz_row0: got %h, required %h", q_zz[0], mk_row(1, 2, 6, 7, 15, 16, 28, 29));
      end
      checks++;
      if (q_zz[7] !== mk_row(36, 37, 49, 50, 58, 59, 63, 64) || q_zz_last[7] !== 1'b1) begin
        errors++; $display("FAIL zz_row7: got %h last=%b, required %h last=1",
                           q_zz[7], q_zz_last[7], mk_row(36, 37, 49, 50, 58, 59, 63, 64));
      end
      for (int r = 0; r < 8; r++) begin
        checks++;
        if (q_zz[r] !== exp_zz[r] || q_zz_last[r] !== (r == 7)) begin
          errors++; $display("FAIL zz_row%0d_model: got %h last=%b, required %h", r, q_zz[r], q_zz_last[r], exp_zz[r]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_eob();
    bit ok;
    clear_all();
    master_tready = 1'b1;
    queue_block(3, 10, 10, 1'b1);
    send_all();
    wait_rows(8, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL eob_rows_timeout: got %0d rows, required 8", q_zz.size());
    end else begin
      checks++;
      if (q_zz[0] !== mk_row(10, 20, 0, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL eob_row0: got %h, required %h", q_zz[0], mk_row(10, 20, 0, 0, 0, 0, 0, 0));
      end
      checks++;
      if (q_zz[1] !== mk_row(30, 0, 0, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL eob_row1: got %h, required %h", q_zz[1], mk_row(30, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int r = 2; r < 8; r++) begin
        checks++;
        if (q_zz[r] !== '0) begin
          errors++; $display("FAIL eob_row%0d: got %h, required 0", r, q_zz[r]);
        end
      end
      checks++;
      if (q_zz_last[7] !== 1'b1) begin
        errors++; $display("FAIL eob_tlast: got %b, required 1", q_zz_last[7]);
      end
    end
    // Full block with no tlast (closes at index 63), then a one-beat block
    // landing in the bank that held 10/20/30.
    queue_block(64, 1000, 1, 1'b0);
    queue_block(1, 99, 0, 1'b1);
    send_all();
    wait_rows(24, ok);
    checks++;
    if (!ok || send_timeout) begin
      errors++; $display("FAIL eob_follow_timeout: got %0d rows, required 24", q_zz.size());
    end else begin
      for (int r = 8; r < 24; r++) begin
        checks++;
        if (q_zz[r] !== exp_zz[r] || q_zz_last[r] !== ((r % 8) == 7)) begin
          errors++; $display("FAIL eob_follow_row%0d: got %h last=%b, required %h", r, q_zz[r], q_zz_last[r], exp_zz[r]);
        end
      end
      checks++;
      if (q_zz[16] !== mk_row(99, 0, 0, 0, 0, 0, 0, 0) || q_zz[17] !== '0) begin
        errors++; $display("FAIL eob_no_leftover: got %h / %h, required %h / 0",
                           q_zz[16], q_zz[17], mk_row(99, 0, 0, 0, 0, 0, 0, 0));
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_backpressure();
    bit ok;
    logic [8*c_w-1:0] first_row;
    clear_all();
    master_tready = 1'b0;
    queue_block(64, 100, 1, 1'b1);
    queue_block(5, 200, 1, 1'b1);
    send_all();
    checks++;
    if (send_timeout || stall_cycles != 0) begin
      errors++; $display("FAIL bp_two_blocks_stalled: stalls=%0d timeout=%b, required 0", stall_cycles, send_timeout);
    end
    checks++;
    if (zz_tready !== 1'b0) begin
      errors++; $display("FAIL bp_tready_drop: got %b, required 0", zz_tready);
    end
    first_row = exp_zz[0];
    checks++;
    if (zz_tvalid !== 1'b1 || zz_tdata !== first_row) begin
      errors++; $display("FAIL bp_stall_row0: tvalid=%b data=%h, required 1 / %h", zz_tvalid, zz_tdata, first_row);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (zz_tdata !== first_row || zz_tlast !== 1'b0 || q_zz.size() != 0) begin
      errors++; $display("FAIL bp_stall_hold: data=%h last=%b rows=%0d, required %h / 0 / 0",
                         zz_tdata, zz_tlast, q_zz.size(), first_row);
    end
    master_tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clock); #1;
      if (i == 7) begin
        checks++;
        if (zz_tready !== 1'b0) begin
          errors++; $display("FAIL bp_tready_before_free: got %b, required 0", zz_tready);
        end
      end
      if (i == 8) begin
        checks++;
        if (zz_tready !== 1'b1) begin
          errors++; $display("FAIL bp_tready_after_free: got %b, required 1", zz_tready);
        end
      end
    end
    repeat (8) @(posedge clock);
    #1;
    checks++;
    if (q_zz.size() != 16) begin
      errors++; $display("FAIL bp_no_bubble: got %0d rows after 16 cycles, required 16", q_zz.size());
    end
    queue_block(64, 300, 3, 1'b1);
    send_all();
    wait_rows(24, ok);
    checks++;
    if (!ok || send_timeout) begin
      errors++; $display("FAIL bp_rows_timeout: got %0d rows, required 24", q_zz.size());
    end else begin
      for (int r = 0; r < 24; r++) begin
        checks++;
        if (q_zz[r] !== exp_zz[r] || q_zz_last[r] !== ((r % 8) == 7)) begin
          errors++; $display("FAIL bp_row%0d: got %h last=%b, required %h", r, q_zz[r], q_zz_last[r], exp_zz[r]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_back_to_back();
    bit ok;
    clear_all();
    master_tready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      queue_block(64, 2000 + 64*b, 1, 1'b1);
    end
    send_all();
    checks++;
    if (send_timeout || stall_cycles != 0) begin
      errors++; $display("FAIL stream_input_stall: stalls=%0d timeout=%b, required 0", stall_cycles, send_timeout);
    end
    wait_rows(32, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stream_rows_timeout: got %0d rows, required 32", q_zz.size());
    end else begin
      for (int r = 0; r < 32; r++) begin
        checks++;
        if (q_zz[r] !== exp_zz[r] || q_zz_last[r] !== ((r % 8) == 7)) begin
          errors++; $display("FAIL stream_zz_row%0d: got %h last=%b, required %h", r, q_zz[r], q_zz_last[r], exp_zz[r]);
        end
        checks++;
        if (q_rs[r] !== exp_rs[r] || q_rs_last[r] !== ((r % 8) == 7)) begin
          errors++; $display("FAIL stream_rs_row%0d: got %h last=%b, required %h", r, q_rs[r], q_rs_last[r], exp_rs[r]);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  task automatic test_raster_and_midreset();
    bit ok;
    logic [8*c_w-1:0] exp_row;
    clear_all();
    master_tready = 1'b1;
    queue_block(64, 0, 1, 1'b1);
    send_all();
    wait_rows(8, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL raster_rows_timeout: got %0d rows, required 8", q_rs.size());
    end else begin
      for (int r = 0; r < 8; r++) begin
        exp_row = mk_row(8*r, 8*r+1, 8*r+2, 8*r+3, 8*r+4, 8*r+5, 8*r+6, 8*r+7);
        checks++;
        if (q_rs[r] !== exp_row || q_rs_last[r] !== (r == 7)) begin
          errors++; $display("FAIL raster_row%0d: got %h last=%b, required %h", r, q_rs[r], q_rs_last[r], exp_row);
        end
      end
    end
    // Partial block, reset part way, then a one-coefficient block
    queue_block(20, 50, 1, 1'b0);
    send_all();
    apply_reset();
    queue_block(1, 5, 0, 1'b1);
    send_all();
    wait_rows(8, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midreset_rows_timeout: got %0d rows, required 8", q_rs.size());
    end else begin
      checks++;
      if (q_rs[0] !== mk_row(5, 0, 0, 0, 0, 0, 0, 0) || q_zz[0] !== mk_row(5, 0, 0, 0, 0, 0, 0, 0)) begin
        errors++; $display("FAIL midreset_row0: got %h / %h, required %h",
                           q_rs[0], q_zz[0], mk_row(5, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int r = 1; r < 8; r++) begin
        checks++;
        if (q_rs[r] !== '0 || q_zz[r] !== '0) begin
          errors++; $display("FAIL midreset_row%0d: got %h / %h, required 0", r, q_rs[r], q_zz[r]);
        end
      end
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    slave_tdata   = '0;
    slave_tvalid  = 1'b0;
    slave_tlast   = 1'b0;
    master_tready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    test_reset();
    test_full_zigzag();
    test_eob();
    test_backpressure();
    test_back_to_back();
    test_raster_and_midreset();

    repeat (2) @(posedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
